// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   First-word-fall-through byte FIFO that feeds the UART transmitter.
//   A producer pushes bytes with an active-low write strobe. The head byte is
//   always visible on data while n_cs is low, and the transmitter pops it by
//   pulling n_rd low on the same edge on which it latches data.
//
// Handshake: a push happens on an edge where n_we == 0 and the FIFO is not
//   full. A pop happens on an edge where n_cs == 0 and n_rd == 0. Both
//   decisions use the pre-edge occupancy, so a write while full is rejected
//   even if a pop frees a slot on that same edge.
//
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   asynchronous reset, active-high
//   n_we    in   write strobe, active-low
//   wdata   in   [DW-1:0] write data
//   n_full  out  low = full, writes ignored
//   n_cs    out  low = head byte valid (non-empty)
//   data    out  [DW-1:0] head-of-FIFO byte
//   n_rd    in   consumer ready/latch, active-low
//   count   out  [AW:0] occupancy 0..2**AW
//   ovf     out  sticky flag: write attempted while full
module uart_tx_fifo #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          n_we,
  input  logic [DW-1:0] wdata,
  output logic          n_full,
  output logic          n_cs,
  output logic [DW-1:0] data,
  input  logic          n_rd,
  output logic [AW:0]   count,
  output logic          ovf
);

  localparam int          DEPTH      = 1 << AW;
  localparam logic [AW:0] FULL_COUNT = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE        = {{AW{1'b0}}, 1'b1};

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          is_full;
  logic          is_empty;
  logic          push;
  logic          pop;

  // Flags come from the registered count only, never from the pointers.
  assign is_full  = (count == FULL_COUNT);
  assign is_empty = (count == '0);
  assign n_full   = ~is_full;
  assign n_cs     = is_empty;

  assign push = ~n_we & ~is_full;
  assign pop  = ~is_empty & ~n_rd;

  // Fall-through read: the head is driven straight from the array.
  assign data = mem[rd_ptr[AW-1:0]];

  // Storage has no reset; stale contents are hidden behind n_cs.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

  // Pointers carry one extra bit and wrap naturally modulo 2**(AW+1).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ONE;
      end
      if (push && !pop) begin
        count <= count + ONE;
      end else if (pop && !push) begin
        count <= count - ONE;
      end
      if (!n_we && is_full) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
//   Bench for uart_tx_fifo (AW=4, DW=8). The reference model is a byte queue
//   (exp_q) plus a sticky overflow bit, updated from the push/pop rules.
module tb_uart_tx_fifo;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int CDIV  = 4;

  logic          clk;
  logic          rst;
  logic          n_we;
  logic [DW-1:0] wdata;
  logic          n_full;
  logic          n_cs;
  logic [DW-1:0] data;
  logic          n_rd;
  logic [AW:0]   count;
  logic          ovf;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] exp_q[$];
  logic          ovf_m;
  logic          last_push;
  logic          last_pop;
  logic [DW-1:0] last_data;

  uart_tx_fifo #(.AW(AW), .DW(DW)) dut (
    .clk    (clk),
    .rst    (rst),
    .n_we   (n_we),
    .wdata  (wdata),
    .n_full (n_full),
    .n_cs   (n_cs),
    .data   (data),
    .n_rd   (n_rd),
    .count  (count),
    .ovf    (ovf)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_count"}, 32'(count), 32'(exp_q.size()));
    chk({tag, "_n_cs"}, 32'(n_cs), 32'(exp_q.size() == 0));
    chk({tag, "_n_full"}, 32'(n_full), 32'(exp_q.size() != DEPTH));
    chk({tag, "_ovf"}, 32'(ovf), 32'(ovf_m));
    if (exp_q.size() != 0) chk({tag, "_data"}, 32'(data), 32'(exp_q[0]));
  endtask

  // ---------------- driver ----------------
  // Drives one cycle of inputs, advances the model, clocks, then checks.
  task automatic step(input logic we_n, input logic [DW-1:0] wd, input logic rd_n,
                      input string tag);
    logic [DW-1:0] pre_data;
    logic [DW-1:0] popped;
    n_we  = we_n;
    wdata = wd;
    n_rd  = rd_n;
    #1;
    pre_data  = data;
    last_pop  = (exp_q.size() != 0) && !rd_n;
    last_push = !we_n && (exp_q.size() != DEPTH);
    if (!we_n && exp_q.size() == DEPTH) ovf_m = 1'b1;
    if (last_pop) begin
      popped    = exp_q.pop_front();
      last_data = pre_data;
      chk({tag, "_pop_data"}, 32'(pre_data), 32'(popped));
    end
    if (last_push) exp_q.push_back(wd);
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic          n_we;
    logic [DW-1:0] wdata;
    logic          n_rd;
    logic [AW:0]   exp_count;
    logic          exp_n_cs;
    logic          exp_n_full;
    logic [DW-1:0] exp_data;
    logic          exp_ovf;
  } vec_t;

  vec_t vecs[8];

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] rx_bytes[$];
    logic [9:0]    tx_sh;
    logic          tx_busy;
    int            tx_div;
    int            tx_bits;
    logic          line_q[$];
    int            wi;
    int            cyc;
    int            sent;
    int            recv;
    int            sz;
    logic          we_r;
    logic          rd_r;

    vecs[0] = '{1'b0, 8'h41, 1'b1, 5'd1, 1'b0, 1'b1, 8'h41, 1'b0};
    vecs[1] = '{1'b0, 8'h42, 1'b1, 5'd2, 1'b0, 1'b1, 8'h41, 1'b0};
    vecs[2] = '{1'b1, 8'h00, 1'b0, 5'd1, 1'b0, 1'b1, 8'h42, 1'b0};
    vecs[3] = '{1'b0, 8'h43, 1'b0, 5'd1, 1'b0, 1'b1, 8'h43, 1'b0};
    vecs[4] = '{1'b1, 8'h00, 1'b0, 5'd0, 1'b1, 1'b1, 8'h00, 1'b0};
    vecs[5] = '{1'b1, 8'h55, 1'b0, 5'd0, 1'b1, 1'b1, 8'h00, 1'b0};
    vecs[6] = '{1'b0, 8'h7E, 1'b0, 5'd1, 1'b0, 1'b1, 8'h7E, 1'b0};
    vecs[7] = '{1'b1, 8'h00, 1'b0, 5'd0, 1'b1, 1'b1, 8'h00, 1'b0};

    rst   = 1'b1;
    n_we  = 1'b1;
    n_rd  = 1'b1;
    wdata = '0;
    ovf_m = 1'b0;
    last_push = 1'b0;
    last_pop  = 1'b0;
    last_data = '0;
    #2;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_n_cs", 32'(n_cs), 32'd1);
    chk("rst_n_full", 32'(n_full), 32'd1);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Table: push, pop, push+pop, empty drain, n_rd while empty, empty+write.
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].n_we, vecs[i].wdata, vecs[i].n_rd, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_tbl_count", i), 32'(count), 32'(vecs[i].exp_count));
      chk($sformatf("vec%0d_tbl_n_cs", i), 32'(n_cs), 32'(vecs[i].exp_n_cs));
      chk($sformatf("vec%0d_tbl_n_full", i), 32'(n_full), 32'(vecs[i].exp_n_full));
      chk($sformatf("vec%0d_tbl_ovf", i), 32'(ovf), 32'(vecs[i].exp_ovf));
      if (!vecs[i].exp_n_cs)
        chk($sformatf("vec%0d_tbl_data", i), 32'(data), 32'(vecs[i].exp_data));
    end

    // Fill to full, then overflow with n_rd high.
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'(8'h80 + i), 1'b1, "fill");
    chk("full_count", 32'(count), 32'd16);
    chk("full_n_full", 32'(n_full), 32'd0);
    step(1'b0, 8'hEE, 1'b1, "ovf_write");
    chk("ovf_flag", 32'(ovf), 32'd1);
    chk("ovf_count", 32'(count), 32'd16);
    chk("ovf_head", 32'(data), 32'h80);

    // Full plus pop on the same edge: write lost, head advances.
    step(1'b0, 8'hDD, 1'b0, "full_pop");
    chk("full_pop_count", 32'(count), 32'd15);
    chk("full_pop_head", 32'(data), 32'h81);
    chk("full_pop_ovf", 32'(ovf), 32'd1);

    // Drain to 5 entries, then reset asynchronously between edges.
    for (int i = 0; i < 10; i++) step(1'b1, 8'h00, 1'b0, "drain5");
    chk("pre_rst_count", 32'(count), 32'd5);
    n_rd = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_n_cs", 32'(n_cs), 32'd1);
    chk("async_rst_n_full", 32'(n_full), 32'd1);
    chk("async_rst_ovf", 32'(ovf), 32'd0);
    exp_q.delete();
    ovf_m = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    step(1'b0, 8'h41, 1'b1, "post_rst");
    chk("post_rst_n_cs", 32'(n_cs), 32'd0);
    chk("post_rst_data", 32'(data), 32'h41);
    step(1'b1, 8'h00, 1'b0, "post_rst_pop");

    // Ordered drain into a serial transmitter model.
    tx_busy = 1'b0;
    tx_div  = 0;
    tx_bits = 0;
    tx_sh   = '1;
    wi      = 0;
    cyc     = 0;
    while (!(wi == 10 && exp_q.size() == 0 && !tx_busy) && cyc < 800) begin
      step((wi < 10) ? 1'b0 : 1'b1, 8'(8'h30 + wi), tx_busy, "tx");
      if (last_push) wi++;
      if (tx_busy) begin
        tx_div++;
        if (tx_div == CDIV) begin
          tx_div = 0;
          tx_sh  = {1'b1, tx_sh[9:1]};
          tx_bits++;
          if (tx_bits == 10) tx_busy = 1'b0;
        end
      end
      if (last_pop) begin
        tx_sh   = {1'b1, last_data, 1'b0};
        tx_busy = 1'b1;
        tx_div  = 0;
        tx_bits = 0;
      end
      line_q.push_back(tx_busy ? tx_sh[0] : 1'b1);
      cyc++;
    end
    chk("tx_timeout", 32'(cyc < 800), 32'd1);
    chk("tx_final_n_cs", 32'(n_cs), 32'd1);
    begin
      int i;
      i = 0;
      while (i + 10 * CDIV <= line_q.size()) begin
        if (line_q[i] == 1'b0) begin
          logic [DW-1:0] b;
          for (int k = 0; k < 8; k++) b[k] = line_q[i + CDIV * (k + 1) + 1];
          chk("tx_stop_bit", 32'(line_q[i + 9 * CDIV + 1]), 32'd1);
          rx_bytes.push_back(b);
          i += 10 * CDIV;
        end else begin
          i++;
        end
      end
    end
    chk("tx_frames", 32'(rx_bytes.size()), 32'd10);
    for (int k = 0; k < rx_bytes.size() && k < 10; k++)
      chk($sformatf("tx_byte%0d", k), 32'(rx_bytes[k]), 32'(8'h30 + k));

    // Random streaming across pointer wraps, occupancy held within 1..15.
    sent = 0;
    recv = 0;
    cyc  = 0;
    while (recv < 40 && cyc < 3000) begin
      sz   = exp_q.size();
      we_r = (sent < 40 && sz <= 14 && $urandom_range(0, 2) != 0) ? 1'b0 : 1'b1;
      rd_r = ((sz >= 2 || sent == 40) && $urandom_range(0, 1) == 1) ? 1'b0 : 1'b1;
      step(we_r, 8'($urandom_range(0, 255)), rd_r, "rand");
      if (last_push) sent++;
      if (last_pop) recv++;
      cyc++;
    end
    chk("rand_timeout", 32'(cyc < 3000), 32'd1);
    chk("rand_recv", 32'(recv), 32'd40);
    chk("rand_ovf", 32'(ovf), 32'd0);
    chk("rand_empty", 32'(n_cs), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
